// File: rtl/alu_writeback_pkg.sv
// Condition codes and flag bit positions shared by the ALU and writeback.
// Flag indices are macros so the ALU can use them without the package.
`ifndef FLAGS_Z
`define FLAGS_Z 0
`define FLAGS_N 1
`define FLAGS_C 2
`define FLAGS_V 3
`endif

package opcodes;

   localparam int FLAGS_W = 4;

   typedef enum logic [3:0] {
      EQ = 4'd0,
      NE,
      CS,
      CC,
      MI,
      PL,
      VS,
      VC,
      HI,
      LS,
      GE,
      LT,
      GT,
      LE,
      AL,
      NV = 4'd15
   } cond_t;

endpackage

// File: rtl/alu_writeback_skid.sv
// Two-entry FIFO with a registered ready, placed ahead of the regfile port.
// Head and tail registers; head is what the consumer sees.
module wb_skid_buffer #(
   parameter int W = 19
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] in_data_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] out_data_o
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] tail_q, tail_d;
   logic         rdy_q, rdy_d;
   logic         push, pop;

   // Next occupancy and entry contents from this cycle's push/pop
   always_comb begin
      push   = in_valid_i & rdy_q;
      pop    = (cnt_q != 2'd0) & out_ready_i;
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      unique case (cnt_q)
         2'd0: begin
            if (push) begin
               head_d = in_data_i;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = in_data_i;
            end else if (push) begin
               tail_d = in_data_i;
               cnt_d  = 2'd2;
            end else if (pop) begin
               cnt_d  = 2'd0;
            end
         end
         2'd2: begin
            if (pop) begin
               head_d = tail_q;
               cnt_d  = 2'd1;
            end
         end
         default: cnt_d = 2'd0;
      endcase
      rdy_d = (cnt_d != 2'd2);
   end

   // State update; reset drops anything in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
         rdy_q  <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         rdy_q  <= rdy_d;
      end
   end

   assign in_ready_o  = rdy_q;
   assign out_valid_o = (cnt_q != 2'd0);
   assign out_data_o  = head_q;

endmodule

// File: rtl/alu_writeback.sv
// Writeback stage: result skid buffer, flags register, branch condition.
// Flags load at accept so a dependent ADC sees the carry next cycle.
module alu_writeback
   import opcodes::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [DATA_W-1:0] AluResult,
   input  logic [3:0]        AluFlags,
   input  logic              InValid,
   output logic              InReady,
   input  logic [REG_AW-1:0] InDest,
   input  logic              InWrEn,
   input  logic              InSetFlags,
   output logic              CarryOut,
   output logic [3:0]        Flags,
   input  cond_t             Cond,
   output logic              CondTrue,
   output logic              WbValid,
   input  logic              WbReady,
   output logic [DATA_W-1:0] WbData,
   output logic [REG_AW-1:0] WbDest,
   output logic              WbWrEn
);

   localparam int PW = DATA_W + REG_AW;

   logic [3:0]    flags_q, flags_d;
   logic          accept;
   logic [PW-1:0] head;
   logic          z, n, c, v;

   assign accept = InValid & InReady;

   wb_skid_buffer #(.W(PW)) u_skid (
      .clk_i      (Clock),
      .rst_i      (Reset),
      .in_valid_i (InValid & InWrEn),
      .in_ready_o (InReady),
      .in_data_i  ({AluResult, InDest}),
      .out_valid_o(WbValid),
      .out_ready_i(WbReady),
      .out_data_o (head)
   );

   assign WbData = head[PW-1:REG_AW];
   assign WbDest = head[REG_AW-1:0];
   assign WbWrEn = WbValid;

   // Flags take the ALU flags only on an accepted flag-setting op
   always_comb begin
      flags_d = flags_q;
      if (accept && InSetFlags) begin
         flags_d = AluFlags;
      end
   end

   // Architectural flags register
   always_ff @(posedge Clock) begin
      if (Reset) begin
         flags_q <= 4'b0000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign Flags    = flags_q;
   assign CarryOut = flags_q[`FLAGS_C];

   assign z = flags_q[`FLAGS_Z];
   assign n = flags_q[`FLAGS_N];
   assign c = flags_q[`FLAGS_C];
   assign v = flags_q[`FLAGS_V];

   // Branch condition against committed flags
   always_comb begin
      CondTrue = 1'b0;
      case (Cond)
         EQ: CondTrue = z;
         NE: CondTrue = ~z;
         CS: CondTrue = c;
         CC: CondTrue = ~c;
         MI: CondTrue = n;
         PL: CondTrue = ~n;
         VS: CondTrue = v;
         VC: CondTrue = ~v;
         HI: CondTrue = c & ~z;
         LS: CondTrue = ~c | z;
         GE: CondTrue = (n == v);
         LT: CondTrue = (n != v);
         GT: CondTrue = ~z & (n == v);
         LE: CondTrue = z | (n != v);
         AL: CondTrue = 1'b1;
         NV: CondTrue = 1'b0;
         default: CondTrue = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_writeback.sv
// Randomised and directed bench for alu_writeback.
// Reference is a queue of pending writes plus a flags word.
module tb_alu_writeback;
   import opcodes::*;

   logic        Clock = 1'b0;
   logic        Reset;
   logic [15:0] AluResult;
   logic [3:0]  AluFlags;
   logic        InValid;
   logic        InReady;
   logic [2:0]  InDest;
   logic        InWrEn;
   logic        InSetFlags;
   logic        CarryOut;
   logic [3:0]  Flags;
   cond_t       Cond;
   logic        CondTrue;
   logic        WbValid;
   logic        WbReady;
   logic [15:0] WbData;
   logic [2:0]  WbDest;
   logic        WbWrEn;

   int vectors = 0;
   int miscompares = 0;

   logic [18:0] mq[$];
   logic [3:0]  m_flags = 4'b0;
   logic        m_ready = 1'b1;
   int          n_push = 0;

   alu_writeback #(.DATA_W(16), .REG_AW(3)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .AluResult (AluResult),
      .AluFlags  (AluFlags),
      .InValid   (InValid),
      .InReady   (InReady),
      .InDest    (InDest),
      .InWrEn    (InWrEn),
      .InSetFlags(InSetFlags),
      .CarryOut  (CarryOut),
      .Flags     (Flags),
      .Cond      (Cond),
      .CondTrue  (CondTrue),
      .WbValid   (WbValid),
      .WbReady   (WbReady),
      .WbData    (WbData),
      .WbDest    (WbDest),
      .WbWrEn    (WbWrEn)
   );

   always #5 Clock = ~Clock;

   function automatic logic cond_ref(cond_t cd, logic [3:0] f);
      logic z, n, c, v;
      z = f[`FLAGS_Z];
      n = f[`FLAGS_N];
      c = f[`FLAGS_C];
      v = f[`FLAGS_V];
      case (cd)
         EQ: return z;
         NE: return !z;
         CS: return c;
         CC: return !c;
         MI: return n;
         PL: return !n;
         VS: return v;
         VC: return !v;
         HI: return c && !z;
         LS: return !c || z;
         GE: return n == v;
         LT: return n != v;
         GT: return !z && (n == v);
         LE: return z || (n != v);
         AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // One clock edge, with the reference updated from pre-edge inputs
   task automatic tick();
      logic acc, pop;
      acc = InValid && m_ready;
      pop = (mq.size() != 0) && WbReady;
      @(posedge Clock);
      if (Reset) begin
         mq.delete();
         m_flags = 4'b0;
      end else begin
         if (pop) void'(mq.pop_front());
         if (acc && InWrEn) begin
            mq.push_back({AluResult, InDest});
            n_push++;
         end
         if (acc && InSetFlags) m_flags = AluFlags;
      end
      m_ready = (mq.size() < 2);
      #1;
   endtask

   task automatic idle();
      InValid = 0;
      InWrEn = 0;
      InSetFlags = 0;
   endtask

   task automatic test_reset();
      Reset = 1;
      idle();
      WbReady = 0;
      AluResult = 0;
      AluFlags = 0;
      InDest = 0;
      Cond = AL;
      tick();
      Reset = 0;
      vectors++;
      if (WbValid !== 1'b0 || WbWrEn !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid got %b/%b want 0", WbValid, WbWrEn);
      end
      vectors++;
      if (InReady !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready got %b want 1", InReady);
      end
      vectors++;
      if (Flags !== 4'b0 || CarryOut !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags got %h/%b want 0", Flags, CarryOut);
      end
      vectors++;
      if (WbData !== 16'h0 || WbDest !== 3'h0) begin
         miscompares++;
         $display("FAIL reset_data got %h/%h want 0", WbData, WbDest);
      end
   endtask

   task automatic test_single();
      WbReady = 1;
      InValid = 1;
      InWrEn = 1;
      AluResult = 16'h1234;
      InDest = 3'd5;
      tick();
      idle();
      vectors++;
      if (WbValid !== 1'b1 || WbData !== 16'h1234 || WbDest !== 3'd5) begin
         miscompares++;
         $display("FAIL single_out got %b %h %h want 1 1234 5",
                  WbValid, WbData, WbDest);
      end
      tick();
      vectors++;
      if (WbValid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_drain got %b want 0", WbValid);
      end
   endtask

   task automatic test_full();
      WbReady = 0;
      InValid = 1;
      InWrEn = 1;
      AluResult = 16'h0001;
      InDest = 3'd1;
      tick();
      AluResult = 16'h0002;
      InDest = 3'd2;
      tick();
      vectors++;
      if (InReady !== 1'b0) begin
         miscompares++;
         $display("FAIL full_ready got %b want 0", InReady);
      end
      AluResult = 16'h0003;
      InDest = 3'd3;
      tick();
      vectors++;
      if (InReady !== 1'b0 || WbData !== 16'h0001) begin
         miscompares++;
         $display("FAIL full_hold got %b %h want 0 0001", InReady, WbData);
      end
      idle();
      WbReady = 1;
      tick();
      vectors++;
      if (WbValid !== 1'b1 || WbData !== 16'h0002 || InReady !== 1'b1) begin
         miscompares++;
         $display("FAIL full_second got %b %h %b want 1 0002 1",
                  WbValid, WbData, InReady);
      end
      tick();
      vectors++;
      if (WbValid !== 1'b0) begin
         miscompares++;
         $display("FAIL full_third_dropped got %b want 0", WbValid);
      end
   endtask

   task automatic test_flags();
      logic [3:0] cf;
      cf = 4'b0;
      cf[`FLAGS_C] = 1'b1;
      AluFlags = cf;
      InValid = 1;
      InSetFlags = 1;
      InWrEn = 0;
      tick();
      vectors++;
      if (CarryOut !== 1'b1 || Flags !== cf || WbValid !== 1'b0) begin
         miscompares++;
         $display("FAIL flags_load got %b %h %b want 1 %h 0",
                  CarryOut, Flags, WbValid, cf);
      end
      AluFlags = 4'hF;
      InSetFlags = 0;
      tick();
      idle();
      vectors++;
      if (Flags !== cf) begin
         miscompares++;
         $display("FAIL flags_hold got %h want %h", Flags, cf);
      end
   endtask

   task automatic test_cond();
      cond_t      cs[6];
      logic [5:0] ex;
      logic [3:0] f;
      cs = '{LT, GE, LE, GT, AL, NV};
      ex = 6'b010101;
      f = 4'b0;
      f[`FLAGS_N] = 1'b1;
      AluFlags = f;
      InValid = 1;
      InSetFlags = 1;
      tick();
      idle();
      for (int i = 0; i < 6; i++) begin
         Cond = cs[i];
         #1;
         vectors++;
         if (CondTrue !== ex[i]) begin
            miscompares++;
            $display("FAIL cond_n %s got %b want %b",
                     cs[i].name(), CondTrue, ex[i]);
         end
      end
      f = 4'b0;
      f[`FLAGS_Z] = 1'b1;
      f[`FLAGS_C] = 1'b1;
      AluFlags = f;
      InValid = 1;
      InSetFlags = 1;
      tick();
      idle();
      Cond = HI;
      #1;
      vectors++;
      if (CondTrue !== 1'b0) begin
         miscompares++;
         $display("FAIL cond_hi got %b want 0", CondTrue);
      end
      Cond = LS;
      #1;
      vectors++;
      if (CondTrue !== 1'b1) begin
         miscompares++;
         $display("FAIL cond_ls got %b want 1", CondTrue);
      end
   endtask

   task automatic test_reset_full();
      WbReady = 0;
      InValid = 1;
      InWrEn = 1;
      AluResult = 16'hAAAA;
      InDest = 3'd6;
      tick();
      AluResult = 16'hBBBB;
      InDest = 3'd7;
      tick();
      idle();
      Reset = 1;
      WbReady = 1;
      tick();
      Reset = 0;
      vectors++;
      if (WbValid !== 1'b0 || InReady !== 1'b1 || Flags !== 4'b0) begin
         miscompares++;
         $display("FAIL reset_full got %b %b %h want 0 1 0",
                  WbValid, InReady, Flags);
      end
      tick();
      vectors++;
      if (WbValid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_full_nowrite got %b want 0", WbValid);
      end
   endtask

   task automatic test_random();
      int n_write;
      n_push = 0;
      n_write = 0;
      for (int i = 0; i < 1100; i++) begin
         if (i < 1000) begin
            InValid = $urandom_range(0, 3) != 0;
            InWrEn = $urandom_range(0, 3) != 0;
            InSetFlags = $urandom_range(0, 1);
         end else begin
            idle();
         end
         AluResult = 16'($urandom);
         InDest = 3'($urandom);
         AluFlags = 4'($urandom);
         Cond = cond_t'($urandom_range(0, 15));
         WbReady = (i >= 1000) ? 1'b1 : ($urandom_range(0, 2) != 0);
         if (WbValid && WbReady) begin
            n_write++;
            vectors++;
            if (mq.size() == 0 || {WbData, WbDest} !== mq[0]) begin
               miscompares++;
               $display("FAIL rnd_write cyc %0d got %h/%h", i, WbData, WbDest);
            end
         end
         tick();
         vectors++;
         if (WbValid !== (mq.size() != 0) || WbWrEn !== WbValid) begin
            miscompares++;
            $display("FAIL rnd_valid cyc %0d got %b want %b",
                     i, WbValid, mq.size() != 0);
         end
         vectors++;
         if (InReady !== m_ready) begin
            miscompares++;
            $display("FAIL rnd_ready cyc %0d got %b want %b",
                     i, InReady, m_ready);
         end
         vectors++;
         if (Flags !== m_flags || CarryOut !== m_flags[`FLAGS_C]) begin
            miscompares++;
            $display("FAIL rnd_flags cyc %0d got %h want %h",
                     i, Flags, m_flags);
         end
         vectors++;
         if (CondTrue !== cond_ref(Cond, m_flags)) begin
            miscompares++;
            $display("FAIL rnd_cond cyc %0d got %b want %b",
                     i, CondTrue, cond_ref(Cond, m_flags));
         end
      end
      vectors++;
      if (n_write != n_push || mq.size() != 0) begin
         miscompares++;
         $display("FAIL rnd_count writes %0d want %0d", n_write, n_push);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_flags();
      test_cond();
      test_reset_full();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Stage directly downstream of the ALU.
- Captures each ALU result into a 2-entry valid/ready skid buffer in front of the register-file write port.
- Owns the architectural flags register (Z, N, C, V) and feeds its C bit back to the ALU carry input for ADC/SUC.
- Evaluates a branch condition code against the committed flags for the control unit.

Parameters:
DATA_W, 16, result/writeback data width
REG_AW, 3, register-file address width (8 registers)

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
AluResult  input  DATA_W  ALU Result
AluFlags  input  4  ALU Flags, indexed by `FLAGS_Z/`FLAGS_N/`FLAGS_C/`FLAGS_V
InValid  input  1  ALU output is a valid instruction result this cycle
InReady  output  1  stage can accept; transfer occurs when InValid & InReady
InDest  input  REG_AW  destination register index
InWrEn  input  1  result is to be written to the register file
InSetFlags  input  1  instruction updates the flags register
CarryOut  output  1  flags-register C bit, drives ALU CarryIn
Flags  output  4  architectural flags register
Cond  input  opcodes::cond_t  condition code to evaluate
CondTrue  output  1  Cond holds for current Flags (combinational)
WbValid  output  1  head entry valid
WbReady  input  1  register file accepts; pop when WbValid & WbReady
WbData  output  DATA_W  head entry data
WbDest  output  REG_AW  head entry destination
WbWrEn  output  1  head entry write enable; equals WbValid

Behaviour:
- Reset (synchronous, highest priority): buffer emptied, WbValid=0, WbWrEn=0, WbData=0, WbDest=0, Flags=0, CarryOut=0, InReady=1. Entries in flight at reset are discarded with no write.
- InReady is a register output: 1 when the buffer holds fewer than 2 entries after this cycle's push/pop. It never depends combinationally on WbReady.
- Accept: InValid & InReady.
  - An accepted instruction with InWrEn=1 is enqueued {AluResult, InDest}.
  - An accepted instruction with InWrEn=0 (compare/test) is not enqueued.
- Latency: an entry accepted into an empty buffer appears on Wb* in the next cycle. Order is strictly FIFO.
- Push and pop in the same cycle:
  - Count is unchanged.
  - With count=1, the new entry becomes head the following cycle.
- Full (count=2): InReady=0. InValid is ignored and no flags update occurs.
- Empty: WbValid=0; WbData/WbDest hold their last values.
- Wb* outputs are stable while WbValid & ~WbReady.
- Flags register:
  - Loads AluFlags on the edge where accept & InSetFlags. Otherwise it holds.
  - Flags update at accept, not at writeback, so a back-to-back ADC sees the prior ADD's carry on CarryOut in the next cycle.
- CarryOut = Flags[`FLAGS_C].
- CondTrue is combinational from registered Flags:
  - EQ: Z; NE: !Z; CS: C; CC: !C; MI: N; PL: !N; VS: V; VC: !V.
  - HI: C&!Z; LS: !C|Z; GE: N==V; LT: N!=V; GT: !Z&(N==V); LE: Z|(N!=V).
  - AL: 1; NV: 0.

Decomposition:
- Package opcodes: cond_t (4-bit enum: EQ=0, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV=15).
- The `FLAGS_* bit-index macros stay where they are and are shared with the ALU.
- One natural sub-module, wb_skid_buffer: the 2-entry FIFO with registered InReady, parameterised on payload width DATA_W+REG_AW.
- Flags register and condition decode live in the top.

Test Plan:
- Reset → WbValid=0, InReady=1, Flags=4'b0000, CarryOut=0. Reset asserted with 2 entries queued → next cycle WbValid=0 and no write occurs.
- Single push AluResult=16'h1234, InDest=5, InWrEn=1, WbReady=1 → next cycle WbValid=1, WbData=16'h1234, WbDest=5; following cycle WbValid=0.
- WbReady=0, push A=16'h0001, then B=16'h0002 → InReady=0 after the second push, and a third InValid is not accepted. Raise WbReady → Wb outputs A then B on consecutive cycles; InReady returns to 1.
- Accept AluFlags with C=1, InSetFlags=1, InWrEn=0 → next cycle CarryOut=1, Flags C=1, and nothing is enqueued. A following accept with InSetFlags=0 leaves Flags unchanged.
- Flags N=1, V=0, Z=0: Cond=LT → CondTrue=1; GE → 0; LE → 1; GT → 0; AL → 1; NV → 0. Flags Z=1, C=1: Cond=HI → 0; LS → 1.
- Simultaneous push/pop at count=1 with random WbReady over 1000 cycles → scoreboard shows every InWrEn=1 result written exactly once, in order, and InReady=1 whenever count<2.
